// File: rtl/uart_cmd_parser_pkg.sv
// Shared definitions for the UART command parser: command codes, the default
// frame start marker and the parser state encoding.
package uart_cmd_parser_pkg;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
  localparam logic [7:0] CMD_WR        = 8'h01;
  localparam logic [7:0] CMD_RD        = 8'h02;

  typedef enum logic [2:0] {
    S_SYNC = 3'd0,
    S_CMD  = 3'd1,
    S_ADDR = 3'd2,
    S_DATA = 3'd3,
    S_CSUM = 3'd4
  } state_t;

  function automatic logic is_cmd(input logic [7:0] b);
    return (b == CMD_WR) || (b == CMD_RD);
  endfunction

endpackage

// File: rtl/uart_cmd_parser_if.sv
// Byte stream from the UART receiver plus the register request bus.
//   in_valid/in_data          : 1-cycle byte strobe and its data
//   wr_en/wr_addr/wr_data     : write request strobe, held address/data
//   rd_en/rd_addr             : read request strobe, held address
//   frame_err/err_count/busy  : drop pulse, saturating drop count, mid-frame flag
// master = byte source / register consumer side, slave = the parser.
interface uart_cmd_parser_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       wr_en;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       rd_en;
  logic [7:0] rd_addr;
  logic       frame_err;
  logic [7:0] err_count;
  logic       busy;

  modport master (
    output in_valid, in_data,
    input  wr_en, wr_addr, wr_data, rd_en, rd_addr, frame_err, err_count, busy
  );

  modport slave (
    input  in_valid, in_data,
    output wr_en, wr_addr, wr_data, rd_en, rd_addr, frame_err, err_count, busy
  );
endinterface

// File: rtl/uart_cmd_parser_gap_timer.sv
// Inter-byte gap counter. Counts up while enabled, clears on clear, and flags
// expire when the count sits at LIMIT-1. Holds at LIMIT-1 until cleared.
//   clk, rst : clock, asynchronous active-high reset
//   clear    : synchronous clear (wins over enable)
//   enable   : count this cycle
//   expire   : count == LIMIT-1
module uart_cmd_parser_gap_timer #(
  parameter int unsigned LIMIT = 17360
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);
  localparam int unsigned W = $clog2(LIMIT + 1);
  localparam logic [W-1:0] TERM = W'(LIMIT - 1);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != TERM)) begin
      count <= count + 1'b1;
    end
  end

  assign expire = (count == TERM);
endmodule

// File: rtl/uart_cmd_parser.sv
// Decodes SYNC/CMD/ADDR/[DATA]/CSUM frames from the UART receiver into
// register write/read request strobes. Bad or stalled frames are dropped,
// pulsed on frame_err and counted (saturating) in err_count.
//   clk, rst : system clock, asynchronous active-high reset
//   bus      : uart_cmd_parser_if.slave (byte stream in, register bus out)
//
// state  | meaning
// S_SYNC | idle, waiting for SYNC_BYTE; other bytes ignored silently
// S_CMD  | expecting command byte (write or read)
// S_ADDR | expecting register address
// S_DATA | expecting write data (write frames only)
// S_CSUM | expecting XOR checksum of CMD, ADDR and DATA
module uart_cmd_parser
  import uart_cmd_parser_pkg::*;
#(
  parameter int unsigned MAIN_CLK       = 100000000,
  parameter int unsigned BAUD           = 115200,
  parameter int unsigned TIMEOUT_CYCLES = (MAIN_CLK / BAUD) * 20,
  parameter logic [7:0]  SYNC_BYTE      = SYNC_BYTE_DEF
) (
  input logic               clk,
  input logic               rst,
  uart_cmd_parser_if.slave  bus
);
  state_t     state;
  logic [7:0] acc;
  logic       is_wr;
  logic [7:0] addr_q;
  logic [7:0] data_q;
  logic       wr_en_q, rd_en_q, frame_err_q;
  logic [7:0] wr_addr_q, wr_data_q, rd_addr_q, err_count_q;
  logic       expire;
  logic       drop;

  uart_cmd_parser_gap_timer #(.LIMIT(TIMEOUT_CYCLES)) u_gap_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (bus.in_valid || (state == S_SYNC)),
    .enable (state != S_SYNC),
    .expire (expire)
  );

  // A byte arriving on the expiry cycle rescues the frame, so timeout only
  // counts when no strobe is present.
  always_comb begin
    drop = 1'b0;
    if (state != S_SYNC) begin
      if (!bus.in_valid) begin
        drop = expire;
      end else begin
        case (state)
          S_CMD:   drop = !is_cmd(bus.in_data);
          S_CSUM:  drop = (bus.in_data != acc);
          default: drop = 1'b0;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_SYNC;
      acc         <= '0;
      is_wr       <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      wr_en_q     <= 1'b0;
      rd_en_q     <= 1'b0;
      frame_err_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      rd_addr_q   <= '0;
      err_count_q <= '0;
    end else begin
      wr_en_q     <= 1'b0;
      rd_en_q     <= 1'b0;
      frame_err_q <= 1'b0;
      if (drop) begin
        frame_err_q <= 1'b1;
        if (err_count_q != 8'hFF) err_count_q <= err_count_q + 8'd1;
        state <= S_SYNC;
        acc   <= '0;
      end else if (bus.in_valid) begin
        case (state)
          S_SYNC: begin
            if (bus.in_data == SYNC_BYTE) begin
              state <= S_CMD;
              acc   <= '0;
            end
          end
          S_CMD: begin
            is_wr <= (bus.in_data == CMD_WR);
            acc   <= bus.in_data;
            state <= S_ADDR;
          end
          S_ADDR: begin
            addr_q <= bus.in_data;
            acc    <= acc ^ bus.in_data;
            state  <= is_wr ? S_DATA : S_CSUM;
          end
          S_DATA: begin
            data_q <= bus.in_data;
            acc    <= acc ^ bus.in_data;
            state  <= S_CSUM;
          end
          S_CSUM: begin
            if (is_wr) begin
              wr_en_q   <= 1'b1;
              wr_addr_q <= addr_q;
              wr_data_q <= data_q;
            end else begin
              rd_en_q   <= 1'b1;
              rd_addr_q <= addr_q;
            end
            acc   <= '0;
            state <= S_SYNC;
          end
          default: state <= S_SYNC;
        endcase
      end
    end
  end

  assign bus.wr_en     = wr_en_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.rd_en     = rd_en_q;
  assign bus.rd_addr   = rd_addr_q;
  assign bus.frame_err = frame_err_q;
  assign bus.err_count = err_count_q;
  assign bus.busy      = (state != S_SYNC);
endmodule

// File: tb/tb_uart_cmd_parser.sv
// Self-checking bench for uart_cmd_parser. A frame-level reference model
// (byte queue per frame, idle-gap count) predicts every output each cycle.
module tb_uart_cmd_parser;
  localparam int T = 24;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  uart_cmd_parser_if bus ();

  uart_cmd_parser #(.TIMEOUT_CYCLES(T)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // reference model state
  bit         m_in_frame;
  logic [7:0] m_frm[$];
  int         m_gap;
  int         m_err;
  logic [7:0] m_wr_addr, m_wr_data, m_rd_addr;
  bit         e_wr, e_rd, e_fe;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("wr_en",     {7'd0, bus.wr_en},     {7'd0, e_wr});
    chk("rd_en",     {7'd0, bus.rd_en},     {7'd0, e_rd});
    chk("frame_err", {7'd0, bus.frame_err}, {7'd0, e_fe});
    chk("err_count", bus.err_count,         8'(m_err));
    chk("busy",      {7'd0, bus.busy},      {7'd0, m_in_frame});
    chk("wr_addr",   bus.wr_addr,           m_wr_addr);
    chk("wr_data",   bus.wr_data,           m_wr_data);
    chk("rd_addr",   bus.rd_addr,           m_rd_addr);
  endtask

  task automatic model_reset();
    m_in_frame = 0; m_frm.delete(); m_gap = 0; m_err = 0;
    m_wr_addr = 0; m_wr_data = 0; m_rd_addr = 0;
    e_wr = 0; e_rd = 0; e_fe = 0;
  endtask

  task automatic model_drop();
    e_fe = 1;
    m_in_frame = 0;
    if (m_err < 255) m_err++;
  endtask

  // one clock edge of the reference model
  task automatic model_edge(input bit v, input logic [7:0] d);
    logic [7:0] x;
    int need;
    e_wr = 0; e_rd = 0; e_fe = 0;
    if (v) begin
      m_gap = 0;
      if (!m_in_frame) begin
        if (d == 8'hA5) begin
          m_in_frame = 1;
          m_frm.delete();
        end
      end else begin
        m_frm.push_back(d);
        need = (m_frm[0] == 8'h01) ? 4 : 3;
        if (m_frm.size() == 1 && d != 8'h01 && d != 8'h02) begin
          model_drop();
        end else if (m_frm.size() == need) begin
          x = 0;
          for (int i = 0; i < need - 1; i++) x ^= m_frm[i];
          if (x == d) begin
            if (m_frm[0] == 8'h01) begin
              e_wr = 1; m_wr_addr = m_frm[1]; m_wr_data = m_frm[2];
            end else begin
              e_rd = 1; m_rd_addr = m_frm[1];
            end
            m_in_frame = 0;
          end else begin
            model_drop();
          end
        end
      end
    end else if (m_in_frame) begin
      m_gap++;
      if (m_gap >= T) model_drop();
    end
  endtask

  // drive one cycle (called at a negedge), then check after the posedge
  task automatic tick(input bit v, input logic [7:0] d);
    bus.in_valid = v;
    bus.in_data  = v ? d : 8'($urandom);
    model_edge(v, d);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic send(input logic [7:0] b, input int idle);
    repeat (idle) tick(0, 8'h00);
    tick(1, b);
  endtask

  task automatic send_seq(input logic [7:0] s[$]);
    foreach (s[i]) send(s[i], 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    model_reset();
    @(negedge clk);
    check_outputs();
    rst = 1'b0;
  endtask

  function automatic int rand_gap();
    int r = $urandom_range(0, 15);
    if (r == 0) return T - 1;
    if (r == 1) return T;
    return $urandom_range(0, 3);
  endfunction

  initial begin
    logic [7:0] cmd, a, dd, cs;
    int kind;

    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    @(negedge clk);
    do_reset();

    // 1: valid write
    send_seq('{8'hA5, 8'h01, 8'h10, 8'h3C, 8'h2D});
    chk("t1_wr_addr", bus.wr_addr, 8'h10);
    chk("t1_wr_data", bus.wr_data, 8'h3C);
    tick(0, 0);

    // 2: valid read
    send_seq('{8'hA5, 8'h02, 8'h7F, 8'h7D});
    chk("t2_rd_addr", bus.rd_addr, 8'h7F);
    tick(0, 0);

    // 3: bad checksum, then bad command
    send_seq('{8'hA5, 8'h01, 8'h10, 8'h3C, 8'h00});
    chk("t3_err1", bus.err_count, 8'd1);
    send_seq('{8'hA5, 8'h03});
    chk("t3_err2", bus.err_count, 8'd2);
    tick(0, 0);

    // 4: leading junk, then a stalled frame times out
    send_seq('{8'h00, 8'hFF, 8'hA5, 8'h01, 8'h10});
    repeat (T) tick(0, 0);
    chk("t4_err3", bus.err_count, 8'd3);
    chk("t4_busy", {7'd0, bus.busy}, 8'd0);
    // byte arriving exactly on the expiry cycle keeps the frame alive
    send_seq('{8'hA5, 8'h01, 8'h10});
    send(8'h3C, T - 1);
    send(8'h2D, T - 1);
    chk("t4_rescue_err", bus.err_count, 8'd3);
    chk("t4_rescue_wr",  {7'd0, bus.wr_en}, 8'd1);
    tick(0, 0);

    // 5: saturation, then reset mid-frame
    for (int i = 0; i < 300; i++) send_seq('{8'hA5, 8'h03});
    chk("t5_sat", bus.err_count, 8'hFF);
    send_seq('{8'hA5, 8'h01});
    do_reset();
    send_seq('{8'hA5, 8'h01, 8'h22, 8'h44, 8'h67});
    chk("t5_post_rst_wr", bus.wr_data, 8'h44);

    // 6: back-to-back writes
    send_seq('{8'hA5, 8'h01, 8'h05, 8'hAA, 8'hAE,
               8'hA5, 8'h01, 8'h06, 8'h55, 8'h52});
    chk("t6_wr_addr", bus.wr_addr, 8'h06);
    chk("t6_wr_data", bus.wr_data, 8'h55);
    tick(0, 0);

    // randomized frames, including junk, mid-frame A5, bad checksums, stalls
    for (int f = 0; f < 80; f++) begin
      if ($urandom_range(0, 4) == 0) send(8'($urandom), rand_gap());
      kind = $urandom_range(0, 9);
      cmd  = (kind < 4) ? 8'h01 : (kind < 8) ? 8'h02 : 8'($urandom);
      a    = ($urandom_range(0, 7) == 0) ? 8'hA5 : 8'($urandom);
      dd   = 8'($urandom);
      cs   = cmd ^ a ^ ((cmd == 8'h01) ? dd : 8'h00);
      if ($urandom_range(0, 5) == 0) cs ^= 8'h40;
      send(8'hA5, rand_gap());
      send(cmd, rand_gap());
      if (cmd == 8'h01 || cmd == 8'h02) begin
        send(a, rand_gap());
        if (cmd == 8'h01) send(dd, rand_gap());
        send(cs, rand_gap());
      end
    end
    repeat (T + 2) tick(0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
